// File: rtl/tpm_pkg.sv
// Shared TPM response constants: structure tags, response codes, header size
// and the response-builder state encoding.
// Imported by tpm_response_builder.
package tpm_pkg;

   localparam logic [15:0] TPM_ST_NO_SESSIONS = 16'h8001;
   localparam logic [15:0] TPM_ST_SESSIONS    = 16'h8002;
   localparam logic [31:0] TPM_RC_SUCCESS     = 32'h0000_0000;
   localparam logic [31:0] TPM_RC_SIZE        = 32'h0000_0095;
   localparam int          TPM_HDR_BYTES      = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PARAM,
      ST_DRAIN,
      ST_FIN
   } rsp_state_t;

endpackage

// File: rtl/tpm_response_builder.sv
// tpm_response_builder: serializes a TPM response as a 10-byte big-endian
// header (tag, responseSize, responseCode) followed by the parameter bytes.
// Error codes go out header-only and their parameter bytes are drained.
// Latency: first header byte one cycle after rsp_start; parameters pass
// through combinationally. The tx byte is held while tx_ready is low.
// Ports:
//   clock, reset_n                  clock, async active-low reset
//   rsp_start/rsp_tag/rsp_rc/rsp_len  response request (taken when not busy)
//   param_valid/param_data/param_ready  parameter byte source
//   tx_valid/tx_data/tx_last/tx_ready   host-bound byte stream
//   busy, rsp_done                  status; rsp_done pulses at completion
// Build option: TPM_RSP_LEN_CHECK_EN turns an oversize successful request
// into a TPM_RC_SIZE header-only response with the payload drained.
module tpm_response_builder
   import tpm_pkg::*;
#(
   parameter int MAX_PARAM_BYTES = 4086,
   parameter int LEN_W           = 13
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             rsp_start,
   input  logic [15:0]      rsp_tag,
   input  logic [31:0]      rsp_rc,
   input  logic [LEN_W-1:0] rsp_len,
   input  logic             param_valid,
   input  logic [7:0]       param_data,
   output logic             param_ready,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   output logic             tx_last,
   input  logic             tx_ready,
   output logic             busy,
   output logic             rsp_done
);

`ifdef TPM_RSP_LEN_CHECK_EN
   localparam bit LEN_CHECK = 1'b1;
`else
   localparam bit LEN_CHECK = 1'b0;
`endif

   localparam logic [3:0] LAST_HDR_IDX = 4'(TPM_HDR_BYTES - 1);

   rsp_state_t       state;
   logic [3:0]       hdr_idx;
   logic [LEN_W-1:0] cnt;      // latched length, later the param/drain down-counter
   logic [15:0]      tag_q;    // effective tag
   logic [31:0]      rc_q;     // effective response code
   logic             err_q;

   logic        len_over;
   logic [31:0] rc_in;
   logic        rc_in_err;
   logic [31:0] size;
   logic [7:0]  hdr_byte;

   // Oversize check folds away entirely when the option is not built in.
   assign len_over  = LEN_CHECK && ({{(32-LEN_W){1'b0}}, rsp_len} > 32'(MAX_PARAM_BYTES));
   assign rc_in     = (len_over && rsp_rc == TPM_RC_SUCCESS) ? TPM_RC_SIZE : rsp_rc;
   assign rc_in_err = (rc_in != TPM_RC_SUCCESS);

   // cnt still holds the latched length throughout HDR; errors report no payload.
   assign size = 32'(TPM_HDR_BYTES) + (err_q ? 32'd0 : {{(32-LEN_W){1'b0}}, cnt});

   always_comb begin
      hdr_byte = 8'h00;
      case (hdr_idx)
         4'd0:    hdr_byte = tag_q[15:8];
         4'd1:    hdr_byte = tag_q[7:0];
         4'd2:    hdr_byte = size[31:24];
         4'd3:    hdr_byte = size[23:16];
         4'd4:    hdr_byte = size[15:8];
         4'd5:    hdr_byte = size[7:0];
         4'd6:    hdr_byte = rc_q[31:24];
         4'd7:    hdr_byte = rc_q[23:16];
         4'd8:    hdr_byte = rc_q[15:8];
         4'd9:    hdr_byte = rc_q[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_comb begin
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      tx_last     = 1'b0;
      param_ready = 1'b0;
      case (state)
         ST_HDR: begin
            tx_valid = 1'b1;
            tx_data  = hdr_byte;
            // Last header byte ends the response unless parameters follow.
            tx_last  = (hdr_idx == LAST_HDR_IDX) && (err_q || cnt == '0);
         end
         ST_PARAM: begin
            tx_valid    = param_valid;
            tx_data     = param_data;
            param_ready = tx_ready;
            tx_last     = (cnt == LEN_W'(1));
         end
         ST_DRAIN: begin
            param_ready = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         hdr_idx  <= '0;
         cnt      <= '0;
         tag_q    <= '0;
         rc_q     <= '0;
         err_q    <= 1'b0;
         busy     <= 1'b0;
         rsp_done <= 1'b0;
      end else begin
         rsp_done <= 1'b0;
         case (state)
            // FIN behaves like IDLE for acceptance so back-to-back responses lose no cycle.
            ST_IDLE, ST_FIN: begin
               if (rsp_start) begin
                  tag_q   <= rc_in_err ? TPM_ST_NO_SESSIONS : rsp_tag;
                  rc_q    <= rc_in;
                  err_q   <= rc_in_err;
                  cnt     <= rsp_len;
                  hdr_idx <= '0;
                  busy    <= 1'b1;
                  state   <= ST_HDR;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_HDR: begin
               if (tx_ready) begin
                  if (hdr_idx == LAST_HDR_IDX) begin
                     if (cnt == '0) begin
                        state    <= ST_FIN;
                        busy     <= 1'b0;
                        rsp_done <= 1'b1;
                     end else if (err_q) begin
                        state <= ST_DRAIN;
                     end else begin
                        state <= ST_PARAM;
                     end
                  end else begin
                     hdr_idx <= hdr_idx + 4'd1;
                  end
               end
            end
            ST_PARAM: begin
               if (param_valid && tx_ready) begin
                  cnt <= cnt - LEN_W'(1);
                  if (cnt == LEN_W'(1)) begin
                     state    <= ST_FIN;
                     busy     <= 1'b0;
                     rsp_done <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (param_valid) begin
                  cnt <= cnt - LEN_W'(1);
                  if (cnt == LEN_W'(1)) begin
                     state    <= ST_FIN;
                     busy     <= 1'b0;
                     rsp_done <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tpm_response_builder.sv
`timescale 1ns/1ps
module tb_tpm_response_builder;
   import tpm_pkg::*;

   localparam int LEN_W   = 13;
   localparam int MAX_LEN = 4086;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             rsp_start;
   logic [15:0]      rsp_tag;
   logic [31:0]      rsp_rc;
   logic [LEN_W-1:0] rsp_len;
   logic             param_valid;
   logic [7:0]       param_data;
   logic             param_ready;
   logic             tx_valid;
   logic [7:0]       tx_data;
   logic             tx_last;
   logic             tx_ready;
   logic             busy;
   logic             rsp_done;

   always #5 clock = ~clock;

   tpm_response_builder #(.MAX_PARAM_BYTES(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .rsp_start(rsp_start), .rsp_tag(rsp_tag), .rsp_rc(rsp_rc), .rsp_len(rsp_len),
      .param_valid(param_valid), .param_data(param_data), .param_ready(param_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
      .busy(busy), .rsp_done(rsp_done)
   );

   int errors = 0;
   int checks = 0;
   int sent   = 0;          // tx bytes handshaken in the current response
   logic [8:0] exp_q[$];    // expected {last, data}
   logic [7:0] pq[$];       // parameter bytes the source still has to deliver

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_tx_last"}, 32'(tx_last), 32'd0);
      check({tag, "_param_ready"}, 32'(param_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_rsp_done"}, 32'(rsp_done), 32'd0);
   endtask

   // Called at a negedge; pushes the expected byte stream and the source bytes.
   task automatic start(input logic [15:0] tag, input logic [31:0] rc, input int len, input bit rnd);
      bit          err;
      logic [31:0] rc_e;
      logic [31:0] size;
      logic [15:0] tag_e;
      logic [79:0] hdr;
      logic [7:0]  b;
      err  = (rc != 32'h0);
      rc_e = rc;
`ifdef TPM_RSP_LEN_CHECK_EN
      if (rc == 32'h0 && len > MAX_LEN) begin
         rc_e = 32'h95;
         err  = 1'b1;
      end
`endif
      tag_e = err ? 16'h8001 : tag;
      size  = err ? 32'd10 : 32'd10 + 32'(len);
      hdr   = {tag_e, size, rc_e};
      for (int i = 0; i < 10; i++)
         exp_q.push_back({(i == 9) && (err || len == 0), hdr[79-8*i -: 8]});
      for (int i = 0; i < len; i++) begin
         b = rnd ? 8'($urandom_range(0, 255)) : 8'(8'hAA + 8'(17 * i));
         pq.push_back(b);
         if (!err) exp_q.push_back({i == len - 1, b});
      end
      sent        = 0;
      rsp_tag     = tag;
      rsp_rc      = rc;
      rsp_len     = LEN_W'(len);
      rsp_start   = 1'b1;
      tx_ready    = 1'b0;
      param_valid = 1'b0;
      @(negedge clock);
      rsp_start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("hdr_latency", 32'(tx_valid), 32'd1);
   endtask

   // Drives tx_ready/param source per cycle and scoreboards the tx stream.
   // stop_bytes >= 0 returns early after that many tx handshakes.
   task automatic run(input bit stall, input bit gaps, input int stop_bytes, input int budget);
      int         cyc = 0;
      int         last_hs = 0;
      int         nbytes = 0;
      bit         done = 1'b0;
      bit         hs_tx, hs_p;
      bit         was_stalled = 1'b0;
      logic [7:0] held = 8'h00;
      logic [8:0] e;
      while (!done && cyc < budget) begin
         tx_ready    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         param_valid = (pq.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
         param_data  = (pq.size() > 0) ? pq[0] : 8'h00;
         #1;
         if (was_stalled) check("stall_hold", 32'(tx_data), 32'(held));
         hs_tx = tx_valid && tx_ready;
         hs_p  = param_valid && param_ready;
         was_stalled = tx_valid && !tx_ready;
         held  = tx_data;
         if (sent >= 10 && exp_q.size() > 0)
            check("param_ready_mirror", 32'(param_ready), 32'(tx_ready));
         if (hs_tx) begin
            if (exp_q.size() == 0) begin
               check("tx_valid_unexpected", 32'(tx_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", 32'({tx_last, tx_data}), 32'(e));
            end
            nbytes++;
            sent++;
         end
         if (hs_tx || hs_p) last_hs = cyc;
         @(posedge clock);
         if (hs_p) void'(pq.pop_front());
         @(negedge clock);
         cyc++;
         if (rsp_done) begin
            done = 1'b1;
            check("done_timing", 32'(cyc - last_hs), 32'd1);
            check("busy_in_fin", 32'(busy), 32'd0);
         end
         if (stop_bytes >= 0 && nbytes == stop_bytes) break;
      end
      if (stop_bytes < 0) begin
         check("done_seen", 32'(done), 32'd1);
         check("tx_bytes_left", 32'(exp_q.size()), 32'd0);
         check("params_left", 32'(pq.size()), 32'd0);
      end else begin
         check("partial_bytes", 32'(nbytes), 32'(stop_bytes));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      rsp_start   = 1'b0;
      rsp_tag     = 16'h0;
      rsp_rc      = 32'h0;
      rsp_len     = '0;
      param_valid = 1'b0;
      param_data  = 8'h00;
      tx_ready    = 1'b0;
      repeat (2) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clock);

      // Header-only success, then one idle cycle after FIN.
      start(16'h8001, 32'h0, 0, 1'b0);
      run(1'b0, 1'b0, -1, 100);
      @(negedge clock);
      check("idle_rsp_done", 32'(rsp_done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Sessions tag with AA BB CC payload.
      start(16'h8002, 32'h0, 3, 1'b0);
      run(1'b0, 1'b0, -1, 100);

      // Error code: header-only, payload drained (start accepted in FIN).
      start(16'h8002, 32'h101, 4, 1'b0);
      run(1'b0, 1'b0, -1, 100);

      // Backpressure and source gaps.
      start(16'h8002, 32'h0, 3, 1'b0);
      run(1'b1, 1'b1, -1, 300);

      // Reset in the middle of the header.
      start(16'h8002, 32'h0, 3, 1'b0);
      run(1'b0, 1'b0, 5, 100);
      check("hdr_byte5_before_reset", 32'(tx_data), 32'(exp_q[0][7:0]));
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_q.delete();
      pq.delete();
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      start(16'h8002, 32'h0, 3, 1'b1);
      run(1'b0, 1'b0, -1, 100);

      // rsp_start while busy is ignored.
      start(16'h8002, 32'h0, 2, 1'b0);
      run(1'b0, 1'b0, 3, 100);
      rsp_tag     = 16'h1234;
      rsp_rc      = 32'h5;
      rsp_len     = LEN_W'(7);
      rsp_start   = 1'b1;
      tx_ready    = 1'b0;
      param_valid = 1'b0;
      @(negedge clock);
      rsp_start = 1'b0;
      check("busy_ignore_start", 32'(busy), 32'd1);
      run(1'b1, 1'b1, -1, 300);

      // Mixed random responses.
      for (int k = 0; k < 6; k++) begin
         start(16'h8002, ($urandom_range(0, 1) != 0) ? 32'h0 : 32'h100 + 32'($urandom_range(0, 255)),
               int'($urandom_range(0, 12)), 1'b1);
         run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 400);
      end

`ifdef TPM_RSP_LEN_CHECK_EN
      // Oversize successful request becomes TPM_RC_SIZE with payload drained.
      start(16'h8002, 32'h0, MAX_LEN + 1, 1'b1);
      run(1'b0, 1'b1, -1, 20000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
